dm_ext: RTL

Parametrised data memory for the MIPS CPU datapath, successor to the word-only DM. Adds byte/halfword stores with byte-lane merging, sign/zero-extended sub-word loads, alignment and range checking, and a hardware clear sweep after reset. It has a `Busy` output so the pipeline can stall. It sits in the MEM stage, between the ALU result / forwarded rt data and the writeback mux.

---
 rtl/dm_pkg.sv | 13 +
 rtl/dm_ext_if.sv | 23 ++
 rtl/dm_lane.sv | 59 +++++
 rtl/dm_ext.sv | 113 +++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// dm_ext shared definitions: access-type codes and sweep FSM states.
package dm_pkg;
  localparam logic [2:0] MEMOP_W  = 3'd0;
  localparam logic [2:0] MEMOP_H  = 3'd1;
  localparam logic [2:0] MEMOP_HS = 3'd2;
  localparam logic [2:0] MEMOP_B  = 3'd3;
  localparam logic [2:0] MEMOP_BS = 3'd4;

  typedef enum logic {
    DM_IDLE  = 1'b0,
    DM_CLEAR = 1'b1
  } dm_state_t;
endpackage

// File: rtl/dm_ext_if.sv
// MEM-stage data memory bus between datapath and dm_ext.
interface dm_ext_if;
  logic        MemWrite;
  logic [2:0]  MemOp;
  logic [31:0] MemAddr;
  logic [31:0] MemData;
  logic [31:0] pc;
  logic [31:0] ReadData;
  logic        AddrExc;
  logic        Busy;

  modport master (
    output MemWrite, MemOp, MemAddr,
    output MemData, pc,
    input  ReadData, AddrExc, Busy
  );

  modport slave (
    input  MemWrite, MemOp, MemAddr,
    input  MemData, pc,
    output ReadData, AddrExc, Busy
  );
endinterface

// File: rtl/dm_lane.sv
// Byte-lane steering: store enables/data and extended load value.
module dm_lane
  import dm_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);
  logic        w_isw;
  logic        w_ish;
  logic        w_isb;
  logic        w_sgn;
  logic [15:0] w_h;
  logic [7:0]  w_b;

  assign w_isw = (i_op == MEMOP_W);
  assign w_ish = (i_op == MEMOP_H) || (i_op == MEMOP_HS);
  assign w_isb = (i_op == MEMOP_B) || (i_op == MEMOP_BS);
  assign w_sgn = (i_op == MEMOP_HS) || (i_op == MEMOP_BS);
  assign w_h   = i_off[1] ? i_rword[31:16] : i_rword[15:0];

  always_comb begin
    unique case (i_off)
      2'd0:    w_b = i_rword[7:0];
      2'd1:    w_b = i_rword[15:8];
      2'd2:    w_b = i_rword[23:16];
      default: w_b = i_rword[31:24];
    endcase
  end

  always_comb begin
    o_be    = 4'h0;
    o_wdata = i_wdata;
    o_rdata = '0;
    unique case (1'b1)
      w_isw: begin
        o_be    = 4'hF;
        o_rdata = i_rword;
      end
      w_ish: begin
        o_be    = i_off[1] ? 4'hC : 4'h3;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{w_sgn & w_h[15]}}, w_h};
      end
      w_isb: begin
        o_be    = 4'h1 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_sgn & w_b[7]}}, w_b};
      end
      default: begin
        o_be = 4'h0;
      end
    endcase
  end
endmodule

// File: rtl/dm_ext.sv
// Data memory with sub-word access, range/alignment checks and clear sweep.
// Define DM_TRACE_EN to print a line for every committed store.
module dm_ext
  import dm_pkg::*;
#(
  parameter int          DEPTH     = 3072,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic     clk,
  input logic     reset,
  dm_ext_if.slave bus
);
  localparam int          AW  = $clog2(DEPTH);
  localparam logic [31:0] LIM = 32'(DEPTH * 4);

  logic [31:0] r_mem [DEPTH];
  dm_state_t   r_state;
  logic [AW-1:0] r_ptr;
  logic        r_busy;

  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_old;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_rdata;
  logic [31:0]   w_merged;
  logic          w_oor;
  logic          w_mis;
  logic          w_rsv;
  logic          w_exc;
  logic          w_clr;
  logic          w_we;
  logic          w_unused;

  assign w_off = bus.MemAddr - BASE_ADDR;
  assign w_idx = w_off[AW+1:2];
  assign w_old = r_mem[w_idx];

  assign w_oor = (bus.MemAddr < BASE_ADDR) || (w_off >= LIM);
  assign w_rsv = (bus.MemOp > MEMOP_BS);
  assign w_mis =
    ((bus.MemOp == MEMOP_W) && (w_off[1:0] != 2'b00)) ||
    (((bus.MemOp == MEMOP_H) || (bus.MemOp == MEMOP_HS))
      && w_off[0]);
  assign w_exc = w_oor || w_mis || w_rsv;

  dm_lane u_lane (
    .i_op    (bus.MemOp),
    .i_off   (w_off[1:0]),
    .i_wdata (bus.MemData),
    .i_rword (w_old),
    .o_be    (w_be),
    .o_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  always_comb begin
    for (int i = 0; i < 4; i++)
      w_merged[8*i +: 8] = w_be[i] ? w_wdata[8*i +: 8]
                                   : w_old[8*i +: 8];
  end

  assign w_clr = reset && (r_state == DM_CLEAR);
  assign w_we  = reset && (r_state == DM_IDLE)
              && bus.MemWrite && !w_exc;

  // Sweep owns the array while clearing; no store can collide with it.
  always_ff @(posedge clk) begin
    if (w_clr)
      r_mem[r_ptr] <= '0;
    else if (w_we)
      r_mem[w_idx] <= w_merged;
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (w_we)
      $display("@%h: *%h <= %h", bus.pc,
               {bus.MemAddr[31:2], 2'b00}, w_merged);
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= DM_CLEAR;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
    end else begin
      unique case (r_state)
        DM_CLEAR: begin
          if (r_ptr == AW'(DEPTH - 1)) begin
            r_state <= DM_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        default: begin
          r_state <= DM_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.AddrExc  = w_exc;
  assign bus.Busy     = r_busy;
  assign bus.ReadData =
    ((r_state == DM_IDLE) && !w_exc) ? w_rdata : '0;

  assign w_unused = ^{bus.pc, w_off[31:AW+2]};
endmodule
